// File: rtl/alu_rs_scheduler_pkg.sv
// Shared configuration for the integer back end: ROB tag width, RS geometry,
// ALU op encodings and CDB field widths used by the ALU, LSB, ROB and this RS.
package alu_rs_scheduler_pkg;

  localparam int ROB_SIZE_BIT = 4;
  localparam int RS_SIZE      = 8;
  localparam int RS_SIZE_BIT  = 3;
  localparam int ALU_OP_W     = 5;
  localparam int CDB_VALUE_W  = 32;

  typedef enum logic [ALU_OP_W-1:0] {
    ALU_ADD  = 5'd0,
    ALU_SUB  = 5'd1,
    ALU_AND  = 5'd2,
    ALU_OR   = 5'd3,
    ALU_XOR  = 5'd4,
    ALU_SLL  = 5'd5,
    ALU_SRL  = 5'd6,
    ALU_SRA  = 5'd7,
    ALU_SLT  = 5'd8,
    ALU_SLTU = 5'd9,
    ALU_BEQ  = 5'd10,
    ALU_BNE  = 5'd11,
    ALU_BLT  = 5'd12,
    ALU_BGE  = 5'd13,
    ALU_BLTU = 5'd14,
    ALU_BGEU = 5'd15,
    ALU_LUI  = 5'd16,
    ALU_AUIPC= 5'd17,
    ALU_JAL  = 5'd18,
    ALU_JALR = 5'd19
  } alu_op_e;

endpackage

// File: rtl/alu_rs_scheduler_priority_enc.sv
// Lowest-index set-bit finder; used for both free-slot search and issue select.
module rs_priority_enc #(
  parameter int N = 8,
  parameter int W = 3
) (
  input  logic [N-1:0] vec_i,
  output logic [W-1:0] idx_o,
  output logic         found_o
);

  // Scan from the top so the lowest set bit is the last one written.
  always_comb begin
    idx_o   = '0;
    found_o = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (vec_i[i]) begin
        idx_o   = W'(i);
        found_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_rs_scheduler.sv
// ALU reservation station: buffers dispatched micro-ops, wakes operands from
// the ALU/LSB CDB ports and issues the lowest-index ready entry each cycle.
module alu_rs_scheduler
  import alu_rs_scheduler_pkg::*;
#(
  parameter int RS_SIZE      = alu_rs_scheduler_pkg::RS_SIZE,
  parameter int RS_SIZE_BIT  = alu_rs_scheduler_pkg::RS_SIZE_BIT,
  parameter int ROB_SIZE_BIT = alu_rs_scheduler_pkg::ROB_SIZE_BIT
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic                    rdy_in,
  input  logic                    clear,
  input  logic                    disp_valid,
  input  logic [ALU_OP_W-1:0]     disp_op,
  input  logic [CDB_VALUE_W-1:0]  disp_vj,
  input  logic [ROB_SIZE_BIT-1:0] disp_qj,
  input  logic                    disp_qj_busy,
  input  logic [CDB_VALUE_W-1:0]  disp_vk,
  input  logic [ROB_SIZE_BIT-1:0] disp_qk,
  input  logic                    disp_qk_busy,
  input  logic [ROB_SIZE_BIT-1:0] disp_rob_idx,
  output logic                    full,
  input  logic                    cdb_alu_valid,
  input  logic [ROB_SIZE_BIT-1:0] cdb_alu_rob_idx,
  input  logic [CDB_VALUE_W-1:0]  cdb_alu_value,
  input  logic                    cdb_lsb_valid,
  input  logic [ROB_SIZE_BIT-1:0] cdb_lsb_rob_idx,
  input  logic [CDB_VALUE_W-1:0]  cdb_lsb_value,
  output logic                    alu_valid,
  output logic [CDB_VALUE_W-1:0]  alu_r1,
  output logic [CDB_VALUE_W-1:0]  alu_r2,
  output logic [ALU_OP_W-1:0]     alu_op,
  output logic [ROB_SIZE_BIT-1:0] alu_rob_idx
);

  logic [RS_SIZE-1:0]      busy_q, busy_d, qjb_q, qjb_d, qkb_q, qkb_d;
  logic [ALU_OP_W-1:0]     op_q  [RS_SIZE];
  logic [ALU_OP_W-1:0]     op_d  [RS_SIZE];
  logic [CDB_VALUE_W-1:0]  vj_q  [RS_SIZE];
  logic [CDB_VALUE_W-1:0]  vj_d  [RS_SIZE];
  logic [CDB_VALUE_W-1:0]  vk_q  [RS_SIZE];
  logic [CDB_VALUE_W-1:0]  vk_d  [RS_SIZE];
  logic [ROB_SIZE_BIT-1:0] qj_q  [RS_SIZE];
  logic [ROB_SIZE_BIT-1:0] qj_d  [RS_SIZE];
  logic [ROB_SIZE_BIT-1:0] qk_q  [RS_SIZE];
  logic [ROB_SIZE_BIT-1:0] qk_d  [RS_SIZE];
  logic [ROB_SIZE_BIT-1:0] rob_q [RS_SIZE];
  logic [ROB_SIZE_BIT-1:0] rob_d [RS_SIZE];

  logic                    alu_valid_q, alu_valid_d;
  logic [CDB_VALUE_W-1:0]  alu_r1_q, alu_r1_d, alu_r2_q, alu_r2_d;
  logic [ALU_OP_W-1:0]     alu_op_q, alu_op_d;
  logic [ROB_SIZE_BIT-1:0] alu_rob_q, alu_rob_d;

  logic [RS_SIZE-1:0]     ready_vec;
  logic [RS_SIZE_BIT-1:0] free_idx, sel_idx;
  logic                   free_found, sel_found;

  assign full      = &busy_q;
  assign ready_vec = busy_q & ~qjb_q & ~qkb_q;

  rs_priority_enc #(.N(RS_SIZE), .W(RS_SIZE_BIT)) u_free_enc (
    .vec_i(~busy_q), .idx_o(free_idx), .found_o(free_found)
  );

  rs_priority_enc #(.N(RS_SIZE), .W(RS_SIZE_BIT)) u_sel_enc (
    .vec_i(ready_vec), .idx_o(sel_idx), .found_o(sel_found)
  );

  always_comb begin
    busy_d = busy_q;
    qjb_d  = qjb_q;
    qkb_d  = qkb_q;
    op_d   = op_q;
    vj_d   = vj_q;
    vk_d   = vk_q;
    qj_d   = qj_q;
    qk_d   = qk_q;
    rob_d  = rob_q;
    alu_valid_d = sel_found;
    alu_r1_d    = alu_r1_q;
    alu_r2_d    = alu_r2_q;
    alu_op_d    = alu_op_q;
    alu_rob_d   = alu_rob_q;

    // Wakeup: the ALU port is checked last so it wins a same-tag collision.
    for (int i = 0; i < RS_SIZE; i++) begin
      if (busy_q[i] && qjb_q[i]) begin
        if (cdb_lsb_valid && cdb_lsb_rob_idx == qj_q[i]) begin
          vj_d[i] = cdb_lsb_value;  qjb_d[i] = 1'b0;
        end
        if (cdb_alu_valid && cdb_alu_rob_idx == qj_q[i]) begin
          vj_d[i] = cdb_alu_value;  qjb_d[i] = 1'b0;
        end
      end
      if (busy_q[i] && qkb_q[i]) begin
        if (cdb_lsb_valid && cdb_lsb_rob_idx == qk_q[i]) begin
          vk_d[i] = cdb_lsb_value;  qkb_d[i] = 1'b0;
        end
        if (cdb_alu_valid && cdb_alu_rob_idx == qk_q[i]) begin
          vk_d[i] = cdb_alu_value;  qkb_d[i] = 1'b0;
        end
      end
    end

    if (sel_found) begin
      busy_d[sel_idx] = 1'b0;
      alu_r1_d  = vj_q[sel_idx];
      alu_r2_d  = vk_q[sel_idx];
      alu_op_d  = op_q[sel_idx];
      alu_rob_d = rob_q[sel_idx];
    end

    // The free slot is never busy, so it cannot collide with wakeup or issue.
    if (disp_valid && free_found) begin
      busy_d[free_idx] = 1'b1;
      op_d[free_idx]   = disp_op;
      rob_d[free_idx]  = disp_rob_idx;
      qj_d[free_idx]   = disp_qj;
      qk_d[free_idx]   = disp_qk;
      vj_d[free_idx]   = disp_vj;
      vk_d[free_idx]   = disp_vk;
      qjb_d[free_idx]  = disp_qj_busy;
      qkb_d[free_idx]  = disp_qk_busy;
      if (disp_qj_busy && cdb_lsb_valid && cdb_lsb_rob_idx == disp_qj) begin
        vj_d[free_idx] = cdb_lsb_value;  qjb_d[free_idx] = 1'b0;
      end
      if (disp_qj_busy && cdb_alu_valid && cdb_alu_rob_idx == disp_qj) begin
        vj_d[free_idx] = cdb_alu_value;  qjb_d[free_idx] = 1'b0;
      end
      if (disp_qk_busy && cdb_lsb_valid && cdb_lsb_rob_idx == disp_qk) begin
        vk_d[free_idx] = cdb_lsb_value;  qkb_d[free_idx] = 1'b0;
      end
      if (disp_qk_busy && cdb_alu_valid && cdb_alu_rob_idx == disp_qk) begin
        vk_d[free_idx] = cdb_alu_value;  qkb_d[free_idx] = 1'b0;
      end
    end
  end

  // Control and ALU-facing registers: reset/flush, then frozen while rdy_in is low.
  always_ff @(posedge clk_in) begin
    if (rst_in || clear) begin
      busy_q      <= '0;
      alu_valid_q <= 1'b0;
      alu_r1_q    <= '0;
      alu_r2_q    <= '0;
      alu_op_q    <= '0;
      alu_rob_q   <= '0;
    end else if (rdy_in) begin
      busy_q      <= busy_d;
      alu_valid_q <= alu_valid_d;
      alu_r1_q    <= alu_r1_d;
      alu_r2_q    <= alu_r2_d;
      alu_op_q    <= alu_op_d;
      alu_rob_q   <= alu_rob_d;
    end
  end

  // Entry payload is only meaningful while busy, so it carries no reset.
  always_ff @(posedge clk_in) begin
    if (rdy_in) begin
      qjb_q <= qjb_d;
      qkb_q <= qkb_d;
      op_q  <= op_d;
      vj_q  <= vj_d;
      vk_q  <= vk_d;
      qj_q  <= qj_d;
      qk_q  <= qk_d;
      rob_q <= rob_d;
    end
  end

  assign alu_valid   = alu_valid_q;
  assign alu_r1      = alu_r1_q;
  assign alu_r2      = alu_r2_q;
  assign alu_op      = alu_op_q;
  assign alu_rob_idx = alu_rob_q;

endmodule

// File: tb/tb_alu_rs_scheduler.sv
// Bench for alu_rs_scheduler: directed scenarios plus random traffic, with a
// slot-array reference model feeding a scoreboard queue that a monitor drains.
module tb_alu_rs_scheduler;

  localparam int RS = 8;

  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in, clear;
  logic        disp_valid, disp_qj_busy, disp_qk_busy;
  logic [4:0]  disp_op;
  logic [31:0] disp_vj, disp_vk;
  logic [3:0]  disp_qj, disp_qk, disp_rob_idx;
  logic        full;
  logic        cdb_alu_valid, cdb_lsb_valid;
  logic [3:0]  cdb_alu_rob_idx, cdb_lsb_rob_idx;
  logic [31:0] cdb_alu_value, cdb_lsb_value;
  logic        alu_valid;
  logic [31:0] alu_r1, alu_r2;
  logic [4:0]  alu_op;
  logic [3:0]  alu_rob_idx;

  always #5 clk_in = ~clk_in;

  alu_rs_scheduler dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear(clear),
    .disp_valid(disp_valid), .disp_op(disp_op),
    .disp_vj(disp_vj), .disp_qj(disp_qj), .disp_qj_busy(disp_qj_busy),
    .disp_vk(disp_vk), .disp_qk(disp_qk), .disp_qk_busy(disp_qk_busy),
    .disp_rob_idx(disp_rob_idx), .full(full),
    .cdb_alu_valid(cdb_alu_valid), .cdb_alu_rob_idx(cdb_alu_rob_idx), .cdb_alu_value(cdb_alu_value),
    .cdb_lsb_valid(cdb_lsb_valid), .cdb_lsb_rob_idx(cdb_lsb_rob_idx), .cdb_lsb_value(cdb_lsb_value),
    .alu_valid(alu_valid), .alu_r1(alu_r1), .alu_r2(alu_r2), .alu_op(alu_op), .alu_rob_idx(alu_rob_idx)
  );

  typedef struct {
    bit        busy;
    bit [4:0]  op;
    bit [31:0] vj, vk;
    bit [3:0]  qj, qk, rob;
    bit        qjb, qkb;
  } ent_t;

  typedef struct {
    bit [31:0] r1, r2;
    bit [4:0]  op;
    bit [3:0]  rob;
  } rec_t;

  ent_t m [RS];
  rec_t exp_q [$];
  rec_t hold, got, iss;
  ent_t newe;
  bit   exp_valid = 1'b0, exp_fresh = 1'b0, mon_en = 1'b0;
  int   sel_m, fr_m;
  int   tests = 0, fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit m_full();
    for (int i = 0; i < RS; i++) if (!m[i].busy) return 1'b0;
    return 1'b1;
  endfunction

  function automatic int m_count();
    int n = 0;
    for (int i = 0; i < RS; i++) if (m[i].busy) n++;
    return n;
  endfunction

  // A pending operand takes a matching broadcast; the ALU port overrides the LSB port.
  function automatic ent_t wake(input ent_t e);
    if (e.qjb && cdb_alu_valid && cdb_alu_rob_idx == e.qj) begin e.vj = cdb_alu_value; e.qjb = 1'b0; end
    else if (e.qjb && cdb_lsb_valid && cdb_lsb_rob_idx == e.qj) begin e.vj = cdb_lsb_value; e.qjb = 1'b0; end
    if (e.qkb && cdb_alu_valid && cdb_alu_rob_idx == e.qk) begin e.vk = cdb_alu_value; e.qkb = 1'b0; end
    else if (e.qkb && cdb_lsb_valid && cdb_lsb_rob_idx == e.qk) begin e.vk = cdb_lsb_value; e.qkb = 1'b0; end
    return e;
  endfunction

  always @(posedge clk_in) begin
    if (rst_in || clear) begin
      for (int i = 0; i < RS; i++) m[i].busy = 1'b0;
      exp_valid = 1'b0;
      exp_fresh = 1'b0;
      hold = '{r1: 0, r2: 0, op: 0, rob: 0};
    end else if (rdy_in) begin
      sel_m = -1;
      fr_m  = -1;
      for (int i = 0; i < RS; i++) begin
        if (sel_m < 0 && m[i].busy && !m[i].qjb && !m[i].qkb) sel_m = i;
        if (fr_m < 0 && !m[i].busy) fr_m = i;
      end
      for (int i = 0; i < RS; i++) if (m[i].busy) m[i] = wake(m[i]);
      if (sel_m >= 0) begin
        iss = '{r1: m[sel_m].vj, r2: m[sel_m].vk, op: m[sel_m].op, rob: m[sel_m].rob};
        m[sel_m].busy = 1'b0;
        exp_q.push_back(iss);
        hold = iss;
        exp_valid = 1'b1;
        exp_fresh = 1'b1;
      end else begin
        exp_valid = 1'b0;
        exp_fresh = 1'b0;
      end
      if (disp_valid && fr_m >= 0) begin
        newe = '{busy: 1'b1, op: disp_op, vj: disp_vj, vk: disp_vk, qj: disp_qj, qk: disp_qk,
                 rob: disp_rob_idx, qjb: disp_qj_busy, qkb: disp_qk_busy};
        m[fr_m] = wake(newe);
      end
    end else begin
      exp_fresh = 1'b0;
    end
  end

  always @(negedge clk_in) begin
    if (mon_en) begin
      chk("full", full, m_full());
      chk("alu_valid", alu_valid, exp_valid);
      if (alu_valid && exp_fresh) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL sb_underflow: got issue rob=%0h expected no issue", alu_rob_idx);
        end else begin
          got = exp_q.pop_front();
          chk("sb_r1", alu_r1, got.r1);
          chk("sb_r2", alu_r2, got.r2);
          chk("sb_op", alu_op, got.op);
          chk("sb_rob", alu_rob_idx, got.rob);
        end
      end else begin
        chk("hold_r1", alu_r1, hold.r1);
        chk("hold_r2", alu_r2, hold.r2);
        chk("hold_op", alu_op, hold.op);
        chk("hold_rob", alu_rob_idx, hold.rob);
      end
    end
  end

  task automatic idle();
    disp_valid = 0; disp_op = 0; disp_vj = 0; disp_vk = 0;
    disp_qj = 0; disp_qk = 0; disp_qj_busy = 0; disp_qk_busy = 0; disp_rob_idx = 0;
    cdb_alu_valid = 0; cdb_alu_rob_idx = 0; cdb_alu_value = 0;
    cdb_lsb_valid = 0; cdb_lsb_rob_idx = 0; cdb_lsb_value = 0;
    clear = 0;
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
    idle();
  endtask

  task automatic disp(input bit [4:0] op, input bit [31:0] vj, input bit [3:0] qj, input bit qjb,
                      input bit [31:0] vk, input bit [3:0] qk, input bit qkb, input bit [3:0] rob);
    disp_valid = 1; disp_op = op; disp_vj = vj; disp_qj = qj; disp_qj_busy = qjb;
    disp_vk = vk; disp_qk = qk; disp_qk_busy = qkb; disp_rob_idx = rob;
  endtask

  task automatic bcast_alu(input bit [3:0] tag, input bit [31:0] val);
    cdb_alu_valid = 1; cdb_alu_rob_idx = tag; cdb_alu_value = val;
  endtask

  task automatic bcast_lsb(input bit [3:0] tag, input bit [31:0] val);
    cdb_lsb_valid = 1; cdb_lsb_rob_idx = tag; cdb_lsb_value = val;
  endtask

  initial begin
    idle();
    rdy_in = 1;
    rst_in = 1;
    tick();
    tick();
    rst_in = 0;
    chk("rst_valid", alu_valid, 0);
    chk("rst_full", full, 0);
    chk("rst_r1", alu_r1, 0);
    chk("rst_rob", alu_rob_idx, 0);
    mon_en = 1;

    // Both operands ready: visible two edges after dispatch.
    disp(5'd0, 32'd5, 4'd0, 0, 32'd7, 4'd0, 0, 4'd3);
    tick();
    chk("t1_latency", alu_valid, 0);
    tick();
    chk("t1_valid", alu_valid, 1);
    chk("t1_r1", alu_r1, 32'd5);
    chk("t1_r2", alu_r2, 32'd7);
    chk("t1_rob", alu_rob_idx, 4'd3);
    chk("t1_full", full, 0);

    // Operand 1 waits for the LSB broadcast of tag 6.
    disp(5'd1, 32'd0, 4'd6, 1, 32'd4, 4'd0, 0, 4'd2);
    tick();
    tick();
    chk("t2_wait", alu_valid, 0);
    bcast_lsb(4'd6, 32'h1234);
    tick();
    chk("t2_no_bypass", alu_valid, 0);
    tick();
    chk("t2_valid", alu_valid, 1);
    chk("t2_r1", alu_r1, 32'h1234);

    // Same-cycle broadcast captured at dispatch.
    disp(5'd2, 32'd11, 4'd0, 0, 32'd0, 4'd2, 1, 4'd5);
    bcast_alu(4'd2, 32'd9);
    tick();
    tick();
    chk("t3_valid", alu_valid, 1);
    chk("t3_r2", alu_r2, 32'd9);

    // Fill, overflow attempt, wake slot 5, refill slot 5.
    for (int i = 0; i < RS; i++) begin
      disp(5'd3, i, 4'(8 + i), 1, 32'(i * 2), 4'd0, 0, 4'(i));
      tick();
    end
    chk("t4_full", full, 1);
    disp(5'd4, 32'd99, 4'd0, 0, 32'd99, 4'd0, 0, 4'd15);
    tick();
    chk("t4_ignored", alu_valid, 0);
    bcast_alu(4'd13, 32'hABCD);
    tick();
    tick();
    chk("t4_issue_rob", alu_rob_idx, 4'd5);
    chk("t4_issue_r1", alu_r1, 32'hABCD);
    chk("t4_full_drop", full, 0);
    disp(5'd5, 32'd1, 4'd0, 0, 32'd2, 4'd0, 0, 4'd9);
    tick();
    chk("t4_refull", full, 1);
    tick();
    chk("t4_slot5_rob", alu_rob_idx, 4'd9);
    clear = 1;
    tick();

    // Entries 1 and 4 wake together and issue back to back.
    disp(5'd6, 0, 4'd10, 1, 0, 4'd0, 0, 4'd0); tick();
    disp(5'd6, 0, 4'd7,  1, 0, 4'd0, 0, 4'd1); tick();
    disp(5'd6, 0, 4'd10, 1, 0, 4'd0, 0, 4'd2); tick();
    disp(5'd6, 0, 4'd10, 1, 0, 4'd0, 0, 4'd3); tick();
    disp(5'd6, 0, 4'd0,  0, 0, 4'd7, 1, 4'd4); tick();
    bcast_lsb(4'd7, 32'h77);
    tick();
    tick();
    chk("t5_first", alu_rob_idx, 4'd1);
    tick();
    chk("t5_second", alu_rob_idx, 4'd4);
    chk("t5_r2", alu_r2, 32'h77);

    // Clear beats dispatch and wakeup in the same cycle.
    disp(5'd6, 0, 4'd10, 1, 0, 4'd0, 0, 4'd5);
    tick();
    clear = 1;
    disp(5'd7, 32'd1, 4'd0, 0, 32'd1, 4'd0, 0, 4'd6);
    bcast_alu(4'd10, 32'd1);
    tick();
    chk("t6_clr_full", full, 0);
    chk("t6_clr_valid", alu_valid, 0);
    tick();
    chk("t6_clr_empty", alu_valid, 0);

    // Freeze with an issue on the outputs.
    disp(5'd8, 32'd1, 4'd0, 0, 32'd1, 4'd0, 0, 4'd1); tick();
    disp(5'd8, 32'd2, 4'd0, 0, 32'd2, 4'd0, 0, 4'd2); tick();
    disp(5'd8, 32'd3, 4'd0, 0, 32'd3, 4'd0, 0, 4'd3); tick();
    rdy_in = 0;
    for (int i = 0; i < 3; i++) begin
      bcast_alu(4'd0, 32'hFFFF);
      tick();
      chk("t6_frz_valid", alu_valid, 1);
      chk("t6_frz_rob", alu_rob_idx, 4'd2);
    end
    rdy_in = 1;
    tick();
    chk("t6_resume", alu_rob_idx, 4'd3);
    tick();

    // Random traffic.
    for (int c = 0; c < 3000; c++) begin
      rdy_in = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 249) == 0) clear = 1;
      if (!m_full() && $urandom_range(0, 1) == 1)
        disp(5'($urandom_range(0, 19)), $urandom, 4'($urandom), 1'($urandom), $urandom,
             4'($urandom), 1'($urandom), 4'($urandom));
      if ($urandom_range(0, 1) == 1) bcast_alu(4'($urandom), $urandom);
      if ($urandom_range(0, 1) == 1) bcast_lsb(4'($urandom), $urandom);
      tick();
    end

    // Drain by sweeping every tag; bounded.
    rdy_in = 1;
    for (int c = 0; c < 200 && m_count() > 0; c++) begin
      bcast_alu(4'(c), $urandom);
      bcast_lsb(4'(c + 8), $urandom);
      tick();
    end
    tick();
    tick();
    chk("drain_full", full, 0);
    chk("drain_valid", alu_valid, 0);
    chk("sb_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
